// File: rtl/asg_seq_pkg.sv
// Shared types and constants for the ASG bank sequencer: segment descriptor,
// table field selects and sequencer states.
package asg_seq_pkg;

  localparam int unsigned RSZ    = 14;
  localparam int unsigned SSZ    = 4;
  localparam int unsigned SEGS   = 1 << SSZ;
  localparam int unsigned PW     = RSZ + 16;
  localparam int unsigned AMP_W  = 14;
  localparam int unsigned NCYC_W = 16;

  localparam logic [2:0] FLD_AMP  = 3'd0;
  localparam logic [2:0] FLD_DC   = 3'd1;
  localparam logic [2:0] FLD_SIZE = 3'd2;
  localparam logic [2:0] FLD_STEP = 3'd3;
  localparam logic [2:0] FLD_OFS  = 3'd4;
  localparam logic [2:0] FLD_NCYC = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    RUN,
    FETCH,
    DONE
  } state_e;

  typedef struct packed {
    logic [AMP_W-1:0]  amp;
    logic [AMP_W-1:0]  dc;
    logic [PW-1:0]     size;
    logic [PW-1:0]     step;
    logic [PW-1:0]     ofs;
    logic [NCYC_W-1:0] ncyc;
  } seg_t;

  // Successor of a segment index, wrapping to 0 at the sequence length.
  function automatic logic [SSZ-1:0] next_idx(input logic [SSZ-1:0] idx,
                                              input logic [SSZ:0]   len);
    return (((SSZ+1)'(idx) + (SSZ+1)'(1)) == len) ? '0 : idx + SSZ'(1);
  endfunction

endpackage

// File: rtl/asg_seq_table.sv
// Segment descriptor table: per-field arrays, CPU write port, 1-cycle load port.
// Readback port is present only when ASG_SEQ_READBACK_EN is defined.
module asg_seq_table
  import asg_seq_pkg::*;
(
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [SSZ+2:0] addr_i,
  input  logic [31:0]    wdata_i,
  input  logic [SSZ-1:0] rd_idx_i,
  output seg_t           rd_seg_o,
  output logic [31:0]    rdata_o
);

  logic [AMP_W-1:0]  amp_q  [SEGS];
  logic [AMP_W-1:0]  dc_q   [SEGS];
  logic [PW-1:0]     size_q [SEGS];
  logic [PW-1:0]     step_q [SEGS];
  logic [PW-1:0]     ofs_q  [SEGS];
  logic [NCYC_W-1:0] ncyc_q [SEGS];
  seg_t              rd_seg_q;

  logic [SSZ-1:0] a_idx;
  logic [2:0]     a_fld;
  logic           unused_wbits;

  assign a_idx = addr_i[SSZ+2:3];
  assign a_fld = addr_i[2:0];
  // upper write bits exceed every field width
  assign unused_wbits = ^wdata_i[31:PW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      case (a_fld)
        FLD_AMP:  amp_q[a_idx]  <= wdata_i[AMP_W-1:0];
        FLD_DC:   dc_q[a_idx]   <= wdata_i[AMP_W-1:0];
        FLD_SIZE: size_q[a_idx] <= wdata_i[PW-1:0];
        FLD_STEP: step_q[a_idx] <= wdata_i[PW-1:0];
        FLD_OFS:  ofs_q[a_idx]  <= wdata_i[PW-1:0];
        FLD_NCYC: ncyc_q[a_idx] <= wdata_i[NCYC_W-1:0];
        default: ;
      endcase
    end
    rd_seg_q <= '{amp:  amp_q[rd_idx_i],  dc:   dc_q[rd_idx_i],
                  size: size_q[rd_idx_i], step: step_q[rd_idx_i],
                  ofs:  ofs_q[rd_idx_i],  ncyc: ncyc_q[rd_idx_i]};
  end

  assign rd_seg_o = rd_seg_q;

`ifdef ASG_SEQ_READBACK_EN
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    case (a_fld)
      FLD_AMP:  rdata_q <= 32'(amp_q[a_idx]);
      FLD_DC:   rdata_q <= 32'(dc_q[a_idx]);
      FLD_SIZE: rdata_q <= 32'(size_q[a_idx]);
      FLD_STEP: rdata_q <= 32'(step_q[a_idx]);
      FLD_OFS:  rdata_q <= 32'(ofs_q[a_idx]);
      FLD_NCYC: rdata_q <= 32'(ncyc_q[a_idx]);
      default:  rdata_q <= '0;
    endcase
  end

  assign rdata_o = rdata_q;
`else
  assign rdata_o = '0;
`endif

endmodule

// File: rtl/asg_bank_sequencer.sv
// Walks a double-buffered ASG channel through a segment list, refilling the
// vacated bank on each swap. Table readback enabled by ASG_SEQ_READBACK_EN.
module asg_bank_sequencer
  import asg_seq_pkg::*;
(
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              tbl_we_i,
  input  logic [SSZ+2:0]    tbl_addr_i,
  input  logic [31:0]       tbl_wdata_i,
  output logic [31:0]       tbl_rdata_o,
  input  logic [SSZ:0]      seq_len_i,
  input  logic              seq_loop_i,
  input  logic              seq_start_i,
  input  logic              seq_stop_i,
  input  logic              cur_buf_i,
  output logic [AMP_W-1:0]  b0_amp_o,
  output logic [AMP_W-1:0]  b0_dc_o,
  output logic [PW-1:0]     b0_size_o,
  output logic [PW-1:0]     b0_step_o,
  output logic [PW-1:0]     b0_ofs_o,
  output logic [NCYC_W-1:0] b0_ncyc_o,
  output logic [AMP_W-1:0]  b1_amp_o,
  output logic [AMP_W-1:0]  b1_dc_o,
  output logic [PW-1:0]     b1_size_o,
  output logic [PW-1:0]     b1_step_o,
  output logic [PW-1:0]     b1_ofs_o,
  output logic [NCYC_W-1:0] b1_ncyc_o,
  output logic              ch_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [SSZ-1:0]    seg_idx_o
);

  state_e         state_q, state_d;
  logic [SSZ:0]   len_q, len_d;
  logic           loop_q, loop_d, last_q, last_d, cb_q, cb_d, v_q, v_d;
  logic [SSZ-1:0] nxt_q, nxt_d, seg_idx_q, seg_idx_d;
  seg_t           b0_q, b0_d, b1_q, b1_d, rd_seg;
  logic           ch_rst_q, ch_rst_d, busy_q, busy_d, done_q, done_d;
  logic [SSZ-1:0] rd_idx_c, n1_c, fin_c;
  logic           swap_c;

  asg_seq_table u_table (
    .clk_i    (dac_clk_i),
    .we_i     (tbl_we_i),
    .addr_i   (tbl_addr_i),
    .wdata_i  (tbl_wdata_i),
    .rd_idx_i (rd_idx_c),
    .rd_seg_o (rd_seg),
    .rdata_o  (tbl_rdata_o)
  );

  assign swap_c = cur_buf_i ^ cb_q;
  assign n1_c   = (len_q > (SSZ+1)'(1)) ? SSZ'(1) : '0;
  assign fin_c  = SSZ'(len_q - (SSZ+1)'(1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    loop_d    = loop_q;
    last_d    = last_q;
    cb_d      = cb_q;
    v_d       = v_q;
    nxt_d     = nxt_q;
    seg_idx_d = seg_idx_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    rd_idx_c  = '0;

    if (seq_stop_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (seq_start_i) begin
          len_d     = (seq_len_i == '0) ? (SSZ+1)'(1) : seq_len_i;
          loop_d    = seq_loop_i;
          seg_idx_d = '0;
          state_d   = LOAD0;
        end
        LOAD0: begin
          b0_d     = rd_seg;
          rd_idx_c = n1_c;
          state_d  = LOAD1;
        end
        LOAD1: begin
          b1_d    = rd_seg;
          nxt_d   = next_idx(n1_c, len_q);
          last_d  = (len_q == (SSZ+1)'(1)) || ((len_q == (SSZ+1)'(2)) && !loop_q);
          cb_d    = cur_buf_i;
          state_d = RUN;
        end
        RUN: begin
          cb_d = cur_buf_i;
          if (swap_c) begin
            // Ends only once the final segment itself has finished playing.
            if (last_q && (seg_idx_q == fin_c)) begin
              state_d = DONE;
            end else begin
              seg_idx_d = next_idx(seg_idx_q, len_q);
              if (!last_q) begin
                v_d      = cb_q;
                rd_idx_c = nxt_q;
                state_d  = FETCH;
              end
            end
          end
        end
        FETCH: begin
          if (v_q) b1_d = rd_seg;
          else     b0_d = rd_seg;
          if ((nxt_q == fin_c) && !loop_q) last_d = 1'b1;
          nxt_d   = next_idx(nxt_q, len_q);
          state_d = RUN;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    ch_rst_d = (state_d != RUN) && (state_d != FETCH);
    busy_d   = (state_d == LOAD0) || (state_d == LOAD1) ||
               (state_d == RUN)   || (state_d == FETCH);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q   <= IDLE;
      len_q     <= (SSZ+1)'(1);
      loop_q    <= 1'b0;
      last_q    <= 1'b0;
      cb_q      <= 1'b0;
      v_q       <= 1'b0;
      nxt_q     <= '0;
      seg_idx_q <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      ch_rst_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      last_q    <= last_d;
      cb_q      <= cb_d;
      v_q       <= v_d;
      nxt_q     <= nxt_d;
      seg_idx_q <= seg_idx_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      ch_rst_q  <= ch_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign b0_amp_o  = b0_q.amp;
  assign b0_dc_o   = b0_q.dc;
  assign b0_size_o = b0_q.size;
  assign b0_step_o = b0_q.step;
  assign b0_ofs_o  = b0_q.ofs;
  assign b0_ncyc_o = b0_q.ncyc;
  assign b1_amp_o  = b1_q.amp;
  assign b1_dc_o   = b1_q.dc;
  assign b1_size_o = b1_q.size;
  assign b1_step_o = b1_q.step;
  assign b1_ofs_o  = b1_q.ofs;
  assign b1_ncyc_o = b1_q.ncyc;
  assign ch_rst_o  = ch_rst_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign seg_idx_o = seg_idx_q;

endmodule

// File: tb/tb_asg_bank_sequencer.sv
// Directed bench for asg_bank_sequencer: vector table of sequence steps plus
// hand-timed sequences for load latency, rapid swaps, reset and readback.
module tb_asg_bank_sequencer;
  import asg_seq_pkg::*;

  logic              dac_clk_i = 1'b0;
  logic              dac_rst_i = 1'b1;
  logic              tbl_we_i = 1'b0;
  logic [SSZ+2:0]    tbl_addr_i = '0;
  logic [31:0]       tbl_wdata_i = '0;
  logic [31:0]       tbl_rdata_o;
  logic [SSZ:0]      seq_len_i = '0;
  logic              seq_loop_i = 1'b0;
  logic              seq_start_i = 1'b0;
  logic              seq_stop_i = 1'b0;
  logic              cur_buf_i = 1'b0;
  logic [AMP_W-1:0]  b0_amp_o, b0_dc_o, b1_amp_o, b1_dc_o;
  logic [PW-1:0]     b0_size_o, b0_step_o, b0_ofs_o, b1_size_o, b1_step_o, b1_ofs_o;
  logic [NCYC_W-1:0] b0_ncyc_o, b1_ncyc_o;
  logic              ch_rst_o, busy_o, done_o;
  logic [SSZ-1:0]    seg_idx_o;

  always #5 dac_clk_i = ~dac_clk_i;

  asg_bank_sequencer dut (
    .dac_clk_i(dac_clk_i), .dac_rst_i(dac_rst_i),
    .tbl_we_i(tbl_we_i), .tbl_addr_i(tbl_addr_i), .tbl_wdata_i(tbl_wdata_i),
    .tbl_rdata_o(tbl_rdata_o),
    .seq_len_i(seq_len_i), .seq_loop_i(seq_loop_i),
    .seq_start_i(seq_start_i), .seq_stop_i(seq_stop_i), .cur_buf_i(cur_buf_i),
    .b0_amp_o(b0_amp_o), .b0_dc_o(b0_dc_o), .b0_size_o(b0_size_o),
    .b0_step_o(b0_step_o), .b0_ofs_o(b0_ofs_o), .b0_ncyc_o(b0_ncyc_o),
    .b1_amp_o(b1_amp_o), .b1_dc_o(b1_dc_o), .b1_size_o(b1_size_o),
    .b1_step_o(b1_step_o), .b1_ofs_o(b1_ofs_o), .b1_ncyc_o(b1_ncyc_o),
    .ch_rst_o(ch_rst_o), .busy_o(busy_o), .done_o(done_o), .seg_idx_o(seg_idx_o)
  );

  localparam int OP_START = 0, OP_TOG = 1, OP_STOP = 2, OP_STOPTOG = 3;
  localparam int NV = 17;

  typedef struct {
    int   op;
    int   len;
    logic loop;
    int   b0;
    int   b1;
    int   seg;
    logic busy;
    logic done;
    logic chrst;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  seg_t m [SEGS];
  vec_t vecs [NV];
  logic done_seen;

  task automatic tick();
    @(posedge dac_clk_i);
    #1;
    if (done_o) done_seen = 1'b1;
  endtask

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic seg_t bank0();
    seg_t s;
    s.amp = b0_amp_o; s.dc = b0_dc_o; s.size = b0_size_o;
    s.step = b0_step_o; s.ofs = b0_ofs_o; s.ncyc = b0_ncyc_o;
    return s;
  endfunction

  function automatic seg_t bank1();
    seg_t s;
    s.amp = b1_amp_o; s.dc = b1_dc_o; s.size = b1_size_o;
    s.step = b1_step_o; s.ofs = b1_ofs_o; s.ncyc = b1_ncyc_o;
    return s;
  endfunction

  function automatic vec_t mk(int op, int len, int loop, int b0, int b1, int seg,
                              int busy, int done, int chrst);
    vec_t v;
    v.op = op; v.len = len; v.loop = (loop != 0);
    v.b0 = b0; v.b1 = b1; v.seg = seg;
    v.busy = (busy != 0); v.done = (done != 0); v.chrst = (chrst != 0);
    return v;
  endfunction

  task automatic wr_field(input int idx, input int fld, input logic [31:0] d);
    logic [SSZ-1:0] i4;
    logic [2:0]     f3;
    i4 = SSZ'(idx);
    f3 = 3'(fld);
    tbl_addr_i  = {i4, f3};
    tbl_wdata_i = d;
    tbl_we_i    = 1'b1;
    tick();
    tbl_we_i    = 1'b0;
  endtask

  task automatic set_seg(input int idx, input seg_t s);
    wr_field(idx, 0, 32'(s.amp));
    wr_field(idx, 1, 32'(s.dc));
    wr_field(idx, 2, 32'(s.size));
    wr_field(idx, 3, 32'(s.step));
    wr_field(idx, 4, 32'(s.ofs));
    wr_field(idx, 5, 32'(s.ncyc));
    m[idx] = s;
  endtask

  task automatic start_seq(input int len, input logic loop);
    cur_buf_i   = 1'b0;
    seq_len_i   = (SSZ+1)'(len);
    seq_loop_i  = loop;
    seq_start_i = 1'b1;
    tick();
    seq_start_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    seg_t s;
    vec_t v;

    vecs[0]  = mk(OP_START,   4, 0, 0, 1, 0, 1, 0, 0);
    vecs[1]  = mk(OP_TOG,     0, 0, 2, 1, 1, 1, 0, 0);
    vecs[2]  = mk(OP_TOG,     0, 0, 2, 3, 2, 1, 0, 0);
    vecs[3]  = mk(OP_TOG,     0, 0, 2, 3, 3, 1, 0, 0);
    vecs[4]  = mk(OP_TOG,     0, 0, 2, 3, 3, 0, 1, 1);
    vecs[5]  = mk(OP_START,   3, 1, 0, 1, 0, 1, 0, 0);
    vecs[6]  = mk(OP_TOG,     0, 0, 2, 1, 1, 1, 0, 0);
    vecs[7]  = mk(OP_TOG,     0, 0, 2, 0, 2, 1, 0, 0);
    vecs[8]  = mk(OP_TOG,     0, 0, 1, 0, 0, 1, 0, 0);
    vecs[9]  = mk(OP_TOG,     0, 0, 1, 2, 1, 1, 0, 0);
    vecs[10] = mk(OP_TOG,     0, 0, 0, 2, 2, 1, 0, 0);
    vecs[11] = mk(OP_TOG,     0, 0, 0, 1, 0, 1, 0, 0);
    vecs[12] = mk(OP_STOP,    0, 0, 0, 1, 0, 0, 0, 1);
    vecs[13] = mk(OP_START,   0, 0, 0, 0, 0, 1, 0, 0);
    vecs[14] = mk(OP_TOG,     0, 0, 0, 0, 0, 0, 1, 1);
    vecs[15] = mk(OP_START,   4, 0, 0, 1, 0, 1, 0, 0);
    vecs[16] = mk(OP_STOPTOG, 0, 0, 0, 1, 0, 0, 0, 1);

    // Reset state
    tick(); tick();
    dac_rst_i = 1'b0;
    chk("rst_b0", bank0(), '0);
    chk("rst_b1", bank1(), '0);
    chk("rst_ch_rst", ch_rst_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_seg_idx", seg_idx_o, '0);

    for (int i = 0; i < int'(SEGS); i++) begin
      s.amp  = AMP_W'(32'h0100 + i);
      s.dc   = AMP_W'(32'h0200 + 3 * i);
      s.size = PW'(32'h0100_0000 + 32'h1000 * i);
      s.step = PW'(32'h0001_0000 + 16 * i);
      s.ofs  = PW'(32'h0000_1000 + 7 * i);
      s.ncyc = NCYC_W'(32'h0010 + i);
      set_seg(i, s);
    end
    // Wide writes must truncate to the field width
    wr_field(0, 0, 32'hABCD_2000); m[0].amp  = 14'h2000;
    wr_field(0, 2, 32'hFFFF_0000); m[0].size = 30'h3FFF_0000;
    wr_field(1, 0, 32'h0000_1000); m[1].amp  = 14'h1000;

    // Basic load: cycle-accurate latency, len=2 no loop
    cur_buf_i   = 1'b0;
    seq_len_i   = 5'd2;
    seq_loop_i  = 1'b0;
    seq_start_i = 1'b1;
    tick();
    seq_start_i = 1'b0;
    chk("basic_busy_load0", busy_o, 1'b1);
    chk("basic_chrst_load0", ch_rst_o, 1'b1);
    tick();
    chk("basic_b0_2clk", bank0(), m[0]);
    tick();
    chk("basic_b1_3clk", bank1(), m[1]);
    chk("basic_chrst_run", ch_rst_o, 1'b0);
    done_seen = 1'b0;
    cur_buf_i = 1'b1;
    tick(); tick(); tick();
    chk("basic_tog1_b0_kept", bank0(), m[0]);
    chk("basic_tog1_seg_idx", seg_idx_o, 4'd1);
    chk("basic_tog1_no_done", done_seen, 1'b0);
    cur_buf_i = 1'b0;
    tick();
    chk("basic_tog2_done", done_o, 1'b1);
    chk("basic_tog2_chrst", ch_rst_o, 1'b1);
    tick();
    chk("basic_done_pulse_end", done_o, 1'b0);
    chk("basic_idle_busy", busy_o, 1'b0);

    // Vector table: ping-pong, loop wrap, len=0, stop with toggle
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      done_seen = 1'b0;
      case (v.op)
        OP_START: start_seq(v.len, v.loop);
        OP_TOG: begin
          cur_buf_i = ~cur_buf_i;
          tick(); tick(); tick();
        end
        OP_STOP: begin
          seq_stop_i = 1'b1;
          tick();
          seq_stop_i = 1'b0;
          tick(); tick();
        end
        default: begin
          seq_stop_i = 1'b1;
          cur_buf_i  = ~cur_buf_i;
          tick();
          seq_stop_i = 1'b0;
          tick(); tick();
        end
      endcase
      chk($sformatf("vec%0d_b0", i), bank0(), m[v.b0]);
      chk($sformatf("vec%0d_b1", i), bank1(), m[v.b1]);
      chk($sformatf("vec%0d_seg_idx", i), seg_idx_o, SSZ'(v.seg));
      chk($sformatf("vec%0d_busy", i), busy_o, v.busy);
      chk($sformatf("vec%0d_done", i), done_seen, v.done);
      chk($sformatf("vec%0d_ch_rst", i), ch_rst_o, v.chrst);
    end

    // Rapid swaps: second toggle lands during FETCH, third two clocks later
    start_seq(4, 1'b1);
    cur_buf_i = 1'b1;
    tick();
    cur_buf_i = 1'b0;
    tick(); tick(); tick();
    chk("rapid_b0_seg2", bank0(), m[2]);
    chk("rapid_b1_seg3", bank1(), m[3]);
    chk("rapid_seg_idx2", seg_idx_o, 4'd2);
    cur_buf_i = 1'b1;
    tick(); tick();
    chk("rapid_b0_seg0", bank0(), m[0]);
    chk("rapid_seg_idx3", seg_idx_o, 4'd3);
    seq_start_i = 1'b1;
    tick();
    seq_start_i = 1'b0;
    tick();
    chk("start_ignored_seg_idx", seg_idx_o, 4'd3);
    chk("start_ignored_b0", bank0(), m[0]);
    chk("start_ignored_busy", busy_o, 1'b1);
    seq_stop_i = 1'b1;
    tick();
    seq_stop_i = 1'b0;
    tick();

    // Reset while refilling a bank
    start_seq(4, 1'b1);
    cur_buf_i = 1'b1;
    tick();
    dac_rst_i = 1'b1;
    tick();
    chk("rstfetch_b0", bank0(), '0);
    chk("rstfetch_b1", bank1(), '0);
    chk("rstfetch_ch_rst", ch_rst_o, 1'b1);
    chk("rstfetch_busy", busy_o, 1'b0);
    chk("rstfetch_seg_idx", seg_idx_o, '0);
    dac_rst_i = 1'b0;
    cur_buf_i = 1'b0;
    tick();

    // Table readback
    wr_field(5, 4, 32'h0000_1234);
    m[5].ofs = 30'h1234;
    tbl_addr_i = {4'd5, 3'd4};
    tick();
`ifdef ASG_SEQ_READBACK_EN
    chk("readback_seg5_ofs", tbl_rdata_o, 32'h0000_1234);
    tbl_addr_i = {4'd5, 3'd6};
    tick();
    chk("readback_field6_zero", tbl_rdata_o, 32'h0);
`else
    chk("readback_disabled_zero", tbl_rdata_o, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
